arb_rsp_router: RTL and testbench
=================================

# arb_rsp_router

Return-path companion to the round-robin request arbiter. It records the index of every grant the arbiter issues, in order, and routes each in-order response from the shared downstream resource back to the requester that was granted. It sits between the shared slave's response channel and the NUM_REQS requester response ports, and it throttles the arbiter when the outstanding-grant budget is exhausted.

## Interface
- NUM_REQS, 4: number of requesters; must match the arbiter. Legal values are 1 or more.
- DEPTH, 4: maximum outstanding grants, i.e. the tracker FIFO depth. Legal values are 1 or more.
- DATA_W, 32: response payload width.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- grant_valid  in  1  the arbiter's grant is being taken this cycle (arbiter pop).
- grant  in  NUM_REQS  one-hot grant vector from the arbiter.
- grant_ready  out  1  tracker can accept a grant; the arbiter pop is gated with this.
- rsp_valid  in  1  response from the shared resource.
- rsp_data  in  DATA_W  response payload.
- rsp_ready  out  1  response accepted this cycle.
- out_valid  out  NUM_REQS  per-requester response valid; at most one bit is set.
- out_data  out  DATA_W  response payload, broadcast to all requesters.
- out_ready  in  NUM_REQS  per-requester response ready.
- outstanding  out  $clog2(DEPTH+1)  number of grants not yet matched by an accepted response.
- err_unexpected  out  1  sticky error: response arrived with no outstanding grant.
- err_grant  out  1  sticky error: grant_valid was asserted with a grant that is not one-hot.

## Operation
- Push: a push happens when grant_valid && grant_ready. The one-hot grant is encoded to an index IDX_W = max(1,$clog2(NUM_REQS)) and pushed into the tracker FIFO.
- Non-one-hot grants:
  - grant == 0: no push; err_grant is set.
  - More than one bit set: the lowest set index is pushed; err_grant is set.
- grant_ready = !full. There is no same-cycle bypass, so a full tracker refuses a grant even when a pop happens in the same cycle.
- Output buffer: one entry, holding obuf_valid, obuf_id and obuf_data.
  - out_valid = obuf_valid ? (1 << obuf_id) : 0.
  - out_data = obuf_data.
- Accept: rsp_ready = !empty && (!obuf_valid || out_ready[obuf_id]). On rsp_valid && rsp_ready:
  - the FIFO head pops;
  - obuf loads {head index, rsp_data};
  - obuf_valid is set.
- Drain: obuf_valid clears when out_ready[obuf_id] is asserted and no new accept happens in the same cycle. If a new accept does happen in that cycle, the buffer is reloaded with the new response.
- outstanding: +1 on push, -1 on pop. A simultaneous push and pop leaves it unchanged. It never exceeds DEPTH.
- err_unexpected is set when rsp_valid && empty. The response is not accepted (rsp_ready = 0), and the flag stays set regardless of whether a push happens in the same cycle.
- Error flags clear only on reset.
- NUM_REQS == 1: the index is always 0 and grant must equal 1.
- All outputs reset to 0 except grant_ready, which resets to 1. Reset clears the FIFO pointers and obuf_valid. A reset in the middle of an operation discards all outstanding grants and any buffered response.

## Timing
- Response latency: rsp accepted in cycle N gives out_valid in cycle N+1.
- Throughput: one response per cycle while the target requester keeps its out_ready high.
- A grant pushed in cycle N can be matched by a response no earlier than cycle N+1 (no FIFO bypass).
- grant_ready, rsp_ready and outstanding are derived from registered state only, with no combinational path from grant_valid. rsp_ready also depends combinationally on out_ready.
- FIFO pointers wrap modulo DEPTH. Full/empty are resolved with an extra pointer bit, or with the outstanding count, so that any DEPTH value is correct, not just powers of two.

## Structure
- Shared soc package holds:
  - a rsp_idx_t typedef sized by IDX_W;
  - the onehot-to-index function (lowest set bit wins), which the arbiter side also uses for its debug and trace logic.
- Sub-module fifo_sync (parameters WIDTH, DEPTH; push/pop/full/empty/count) holds the grant indices. The router instantiates it with WIDTH=IDX_W.
- The output buffer and the error flags live in arb_rsp_router itself.

## Test plan
- Basic routing: grants 0001, 0100, 0010, then three responses A, B, C with all out_ready high. Required: out_valid = 0001/A, 0100/B, 0010/C on consecutive cycles, each 1 cycle after its accept; outstanding goes 3 → 0.
- Full tracker: DEPTH=4, 4 grants with no responses. Required: grant_ready = 0 and outstanding = 4; a 5th grant_valid causes no push. After one response is accepted, grant_ready = 1 the next cycle.
- Backpressure: buffered response for requester 2 with out_ready[2] = 0, second response pending. Required: rsp_ready = 0 and out_data held stable. Raising out_ready[2] accepts the second response in the same cycle, and it appears the next cycle.
- Errors:
  - rsp_valid while empty: rsp_ready = 0 and err_unexpected = 1, staying set.
  - grant = 0000 with grant_valid: no push, err_grant = 1.
  - grant = 0110: index 1 is pushed, err_grant = 1.
- Simultaneous push and pop at outstanding = 2: outstanding stays 2, and routing order is preserved across FIFO pointer wrap-around over 10 or more transactions.
- Asynchronous reset asserted with 3 outstanding grants and a buffered response: immediately out_valid = 0, outstanding = 0, grant_ready = 1, and both error flags = 0.

Source files
------------

// File: rtl/arb_rsp_router_pkg.sv
// Shared return-path types and helpers for the request arbiter and its response router.
package arb_rsp_router_pkg;

  localparam int MAX_REQS     = 64;
  localparam int DEF_NUM_REQS = 4;
  localparam int DEF_IDX_W    = (DEF_NUM_REQS > 1) ? $clog2(DEF_NUM_REQS) : 1;

  typedef logic [DEF_IDX_W-1:0] rsp_idx_t;

  // Lowest set bit wins; an all-zero vector maps to 0.
  function automatic int onehot_to_idx(input logic [MAX_REQS-1:0] v);
    int r;
    r = 0;
    for (int i = MAX_REQS - 1; i >= 0; i--)
      if (v[i]) r = i;
    return r;
  endfunction

endpackage

// File: rtl/arb_rsp_router_fifo_sync.sv
// Synchronous FIFO holding grant indices; occupancy count resolves full/empty for any DEPTH.
module fifo_sync #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; only entries between pointers are ever read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/arb_rsp_router.sv
// Records arbiter grant order and routes in-order responses back to the granted requester.
module arb_rsp_router
  import arb_rsp_router_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                grant_valid,
  input  logic [NUM_REQS-1:0] grant,
  output logic                grant_ready,
  input  logic                rsp_valid,
  input  logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_ready,
  output logic [NUM_REQS-1:0] out_valid,
  output logic [DATA_W-1:0]   out_data,
  input  logic [NUM_REQS-1:0] out_ready,
  output logic [CW-1:0]       outstanding,
  output logic                err_unexpected,
  output logic                err_grant
);

  logic             full, empty;
  logic             push, accept, drain, onehot;
  logic [IDX_W-1:0] gidx, head;
  logic             obuf_valid;
  logic [IDX_W-1:0] obuf_id;
  logic [DATA_W-1:0] obuf_data;

  assign onehot = (grant != '0) && ((grant & (grant - 1'b1)) == '0);
  assign gidx   = IDX_W'(onehot_to_idx(MAX_REQS'(grant)));
  assign push   = grant_valid && grant_ready && (grant != '0);

  assign grant_ready = !full;
  assign rsp_ready   = !empty && (!obuf_valid || out_ready[obuf_id]);
  assign accept      = rsp_valid && rsp_ready;
  assign drain       = obuf_valid && out_ready[obuf_id];

  assign out_valid = obuf_valid ? (NUM_REQS'(1) << obuf_id) : '0;
  assign out_data  = obuf_data;

  fifo_sync #(.WIDTH(IDX_W), .DEPTH(DEPTH)) u_trk (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (gidx),
    .pop   (accept),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (outstanding)
  );

  // Single-entry output buffer: reload on accept, otherwise clear once the target takes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      obuf_valid <= 1'b0;
      obuf_id    <= '0;
      obuf_data  <= '0;
    end else if (accept) begin
      obuf_valid <= 1'b1;
      obuf_id    <= head;
      obuf_data  <= rsp_data;
    end else if (drain) begin
      obuf_valid <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_unexpected <= 1'b0;
      err_grant      <= 1'b0;
    end else begin
      if (rsp_valid && empty)      err_unexpected <= 1'b1;
      if (grant_valid && !onehot)  err_grant      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_rsp_router.sv
// Bench for arb_rsp_router: directed table, corner sequences, randomized run vs queue model.
module tb_arb_rsp_router;

  localparam int NR = 4;
  localparam int DP = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        grant_valid = 1'b0;
  logic [3:0]  grant = '0;
  logic        grant_ready;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        rsp_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_ready = '0;
  logic [2:0]  outstanding;
  logic        err_unexpected, err_grant;

  arb_rsp_router #(.NUM_REQS(NR), .DEPTH(DP), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .grant_valid(grant_valid), .grant(grant), .grant_ready(grant_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .outstanding(outstanding),
    .err_unexpected(err_unexpected), .err_grant(err_grant)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: queue of granted requester numbers plus one held response.
  int          q[$];
  bit          mv;
  int          mid;
  logic [31:0] md;
  bit          meu, meg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic int lowest(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  function automatic bit is_onehot(input logic [3:0] g);
    return $countones(g) == 1;
  endfunction

  task automatic model_reset();
    q.delete();
    mv = 0; mid = 0; md = '0; meu = 0; meg = 0;
  endtask

  // Compare DUT to model for the current cycle, advance the model, then cross one clock edge.
  task automatic step();
    int  pre;
    bit  acc, gr;
    #1;
    pre = q.size();
    gr  = pre < DP;
    acc = rsp_valid && pre > 0 && (!mv || out_ready[mid]);
    chk("m_grant_ready", {31'd0, grant_ready}, {31'd0, gr});
    chk("m_rsp_ready", {31'd0, rsp_ready}, {31'd0, pre > 0 && (!mv || out_ready[mid])});
    chk("m_out_valid", {28'd0, out_valid}, mv ? (32'd1 << mid) : 32'd0);
    chk("m_out_data", out_data, md);
    chk("m_outstanding", {29'd0, outstanding}, pre);
    chk("m_err_unexp", {31'd0, err_unexpected}, {31'd0, meu});
    chk("m_err_grant", {31'd0, err_grant}, {31'd0, meg});
    if (rsp_valid && pre == 0) meu = 1;
    if (grant_valid && !is_onehot(grant)) meg = 1;
    if (acc) begin
      mid = q.pop_front(); md = rsp_data; mv = 1;
    end else if (mv && out_ready[mid]) begin
      mv = 0;
    end
    if (grant_valid && gr && grant != 0) q.push_back(lowest(grant));
    @(posedge clock); #1;
    cyc++;
  endtask

  typedef struct {
    logic        gv;
    logic [3:0]  g;
    logic        rv;
    logic [31:0] rd;
    logic [3:0]  ordy;
    logic        e_gr;
    logic        e_rr;
    logic [3:0]  e_ov;
    logic [31:0] e_od;
    logic [2:0]  e_os;
    logic        e_eu;
    logic        e_eg;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic gv, input logic [3:0] g, input logic rv,
                              input logic [31:0] rd, input logic [3:0] ordy,
                              input logic e_gr, input logic e_rr, input logic [3:0] e_ov,
                              input logic [31:0] e_od, input logic [2:0] e_os,
                              input logic e_eu, input logic e_eg);
    vec_t v;
    v.gv = gv; v.g = g; v.rv = rv; v.rd = rd; v.ordy = ordy;
    v.e_gr = e_gr; v.e_rr = e_rr; v.e_ov = e_ov; v.e_od = e_od; v.e_os = e_os;
    v.e_eu = e_eu; v.e_eg = e_eg;
    return v;
  endfunction

  initial begin
    //              gv g      rv rd     ordy    gr rr ov      od     os eu eg
    tbl[0]  = mk(0, 4'h0, 0, 32'h0,  4'hF,  1, 0, 4'h0, 32'h0,  0, 0, 0);
    tbl[1]  = mk(1, 4'h1, 0, 32'h0,  4'hF,  1, 0, 4'h0, 32'h0,  0, 0, 0);
    tbl[2]  = mk(1, 4'h4, 0, 32'h0,  4'hF,  1, 1, 4'h0, 32'h0,  1, 0, 0);
    tbl[3]  = mk(1, 4'h2, 0, 32'h0,  4'hF,  1, 1, 4'h0, 32'h0,  2, 0, 0);
    tbl[4]  = mk(0, 4'h0, 1, 32'hA,  4'hF,  1, 1, 4'h0, 32'h0,  3, 0, 0);
    tbl[5]  = mk(0, 4'h0, 1, 32'hB,  4'hF,  1, 1, 4'h1, 32'hA,  2, 0, 0);
    tbl[6]  = mk(0, 4'h0, 1, 32'hC,  4'hF,  1, 1, 4'h4, 32'hB,  1, 0, 0);
    tbl[7]  = mk(0, 4'h0, 0, 32'h0,  4'hF,  1, 0, 4'h2, 32'hC,  0, 0, 0);
    tbl[8]  = mk(0, 4'h0, 0, 32'h0,  4'hF,  1, 0, 4'h0, 32'hC,  0, 0, 0);
    tbl[9]  = mk(0, 4'h0, 1, 32'hDEAD, 4'hF, 1, 0, 4'h0, 32'hC, 0, 0, 0);
    tbl[10] = mk(0, 4'h0, 0, 32'h0,  4'hF,  1, 0, 4'h0, 32'hC,  0, 1, 0);
    tbl[11] = mk(1, 4'h0, 0, 32'h0,  4'hF,  1, 0, 4'h0, 32'hC,  0, 1, 0);
    tbl[12] = mk(0, 4'h0, 0, 32'h0,  4'hF,  1, 0, 4'h0, 32'hC,  0, 1, 1);
    tbl[13] = mk(1, 4'h6, 0, 32'h0,  4'hF,  1, 0, 4'h0, 32'hC,  0, 1, 1);
    tbl[14] = mk(0, 4'h0, 0, 32'h0,  4'hF,  1, 1, 4'h0, 32'hC,  1, 1, 1);
    tbl[15] = mk(0, 4'h0, 1, 32'h55, 4'hF,  1, 1, 4'h0, 32'hC,  1, 1, 1);
    tbl[16] = mk(0, 4'h0, 0, 32'h0,  4'h0,  1, 0, 4'h2, 32'h55, 0, 1, 1);
    tbl[17] = mk(0, 4'h0, 0, 32'h0,  4'hF,  1, 0, 4'h2, 32'h55, 0, 1, 1);
    tbl[18] = mk(0, 4'h0, 0, 32'h0,  4'hF,  1, 0, 4'h0, 32'h55, 0, 1, 1);

    // Reset state, observed while reset is held and before any clock edge.
    model_reset();
    #1;
    chk("rst_gready", {31'd0, grant_ready}, 32'd1);
    chk("rst_rready", {31'd0, rsp_ready}, 32'd0);
    chk("rst_ovalid", {28'd0, out_valid}, 32'd0);
    chk("rst_outst", {29'd0, outstanding}, 32'd0);
    chk("rst_errs", {30'd0, err_unexpected, err_grant}, 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // Directed table: routing order, latency, errors, non-one-hot grants.
    for (int i = 0; i < 19; i++) begin
      grant_valid = tbl[i].gv; grant = tbl[i].g;
      rsp_valid = tbl[i].rv; rsp_data = tbl[i].rd; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("t%0d_gready", i), {31'd0, grant_ready}, {31'd0, tbl[i].e_gr});
      chk($sformatf("t%0d_rready", i), {31'd0, rsp_ready}, {31'd0, tbl[i].e_rr});
      chk($sformatf("t%0d_ovalid", i), {28'd0, out_valid}, {28'd0, tbl[i].e_ov});
      chk($sformatf("t%0d_odata", i), out_data, tbl[i].e_od);
      chk($sformatf("t%0d_outst", i), {29'd0, outstanding}, {29'd0, tbl[i].e_os});
      chk($sformatf("t%0d_eunexp", i), {31'd0, err_unexpected}, {31'd0, tbl[i].e_eu});
      chk($sformatf("t%0d_egrant", i), {31'd0, err_grant}, {31'd0, tbl[i].e_eg});
      step();
    end

    // Full tracker: four grants fill it, a fifth is refused, one response frees a slot.
    grant_valid = 0; rsp_valid = 0; out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      grant_valid = 1; grant = 4'(1 << i); step();
    end
    grant_valid = 0;
    #1;
    chk("full_gready", {31'd0, grant_ready}, 32'd0);
    chk("full_outst", {29'd0, outstanding}, 32'd4);
    grant_valid = 1; grant = 4'h1; step();
    grant_valid = 0;
    #1;
    chk("full_nopush", {29'd0, outstanding}, 32'd4);
    rsp_valid = 1; rsp_data = 32'h1111; step();
    rsp_valid = 0;
    #1;
    chk("full_reopen", {31'd0, grant_ready}, 32'd1);
    rsp_valid = 1;
    for (int i = 0; i < 3; i++) begin rsp_data = 32'h2000 + i; step(); end
    rsp_valid = 0; step(); step();

    // Backpressure: requester 2 stalls with a second response waiting.
    grant_valid = 1; grant = 4'h4; step(); step();
    grant_valid = 0; out_ready = 4'hB;
    rsp_valid = 1; rsp_data = 32'hD1; step();
    rsp_data = 32'hD2;
    #1;
    chk("bp_rready", {31'd0, rsp_ready}, 32'd0);
    chk("bp_ovalid", {28'd0, out_valid}, 32'h4);
    step(); step();
    #1;
    chk("bp_hold", out_data, 32'hD1);
    out_ready = 4'hF;
    #1;
    chk("bp_accept", {31'd0, rsp_ready}, 32'd1);
    step();
    rsp_valid = 0;
    #1;
    chk("bp_next_data", out_data, 32'hD2);
    chk("bp_next_valid", {28'd0, out_valid}, 32'h4);
    step(); step();

    // Simultaneous push and pop at two outstanding, across pointer wrap.
    grant_valid = 1; grant = 4'h1; step();
    grant = 4'h2; step();
    for (int k = 0; k < 12; k++) begin
      grant = 4'(1 << (k % 4)); rsp_valid = 1; rsp_data = 32'(100 + k);
      #1;
      chk("simul_outst", {29'd0, outstanding}, 32'd2);
      step();
    end
    grant_valid = 0; step(); step(); rsp_valid = 0; step(); step();

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 600; n++) begin
      grant_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) grant = 4'($urandom);
      else grant = 4'(1 << $urandom_range(0, 3));
      rsp_valid = ($urandom_range(0, 9) < 6);
      rsp_data  = $urandom;
      out_ready = 4'($urandom | $urandom);
      step();
    end

    // Drain, then set up three outstanding grants plus a buffered response.
    grant_valid = 0; rsp_valid = 1; out_ready = 4'hF;
    for (int i = 0; i < 6; i++) step();
    rsp_valid = 0; step();
    grant_valid = 1;
    for (int i = 0; i < 4; i++) begin grant = 4'(1 << i); step(); end
    grant_valid = 0; rsp_valid = 1; rsp_data = 32'hBEEF; step();
    rsp_valid = 0; out_ready = 4'h0;
    #1;
    chk("pre_rst_ovalid", {28'd0, out_valid}, 32'h1);
    chk("pre_rst_outst", {29'd0, outstanding}, 32'd3);
    chk("pre_rst_errs", {30'd0, err_unexpected, err_grant}, 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("arst_ovalid", {28'd0, out_valid}, 32'd0);
    chk("arst_outst", {29'd0, outstanding}, 32'd0);
    chk("arst_gready", {31'd0, grant_ready}, 32'd1);
    chk("arst_errs", {30'd0, err_unexpected, err_grant}, 32'd0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      grant_valid = 1'($urandom_range(0, 1));
      grant = 4'(1 << $urandom_range(0, 3));
      rsp_valid = 1'($urandom_range(0, 1));
      rsp_data = $urandom;
      out_ready = 4'($urandom | $urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
